// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StFetch = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam logic PortData  = 1'b1;
    localparam logic PortFetch = 1'b0;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles an access waits for its ack; flags the cycle on which the wait budget runs out.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] LastCnt = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expiry fires on the TIMEOUT-th ack-less cycle so the request lasts exactly TIMEOUT cycles.
    assign expired_o = (TIMEOUT > 0) && en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage loads/stores.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    arb_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              port_q, port_d;
    logic              killed_q, killed_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic busy, expired, dm_any, resp_cycle;

    assign busy       = (state_q == StData) || (state_q == StFetch);
    assign dm_any     = dm_read_i | dm_write_i;
    assign resp_cycle = (state_q == StResp);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == StIdle),
        .en_i      (busy && !mem_ack_i),
        .expired_o (expired)
    );

    // A flush landing in the response cycle still suppresses the fetch completion.
    assign dm_valid_o  = resp_cycle && (port_q == PortData);
    assign if_valid_o  = resp_cycle && (port_q == PortFetch) && !killed_q && !if_flush_i;
    assign bus_err_o   = err_q && (dm_valid_o || if_valid_o);
    assign dm_rdata_o  = (dm_valid_o && !we_q) ? resp_q : dm_rdata_q;
    assign if_rdata_o  = if_valid_o ? resp_q : if_rdata_q;
    assign stall_if_o  = if_req_i & ~if_valid_o;
    assign stall_mem_o = dm_any & ~dm_valid_o;

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        killed_d   = killed_q;
        err_d      = err_q;
        resp_d     = resp_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            StIdle: begin
                // Data belongs to the older instruction, so it always wins.
                if (dm_any) begin
                    state_d  = StData;
                    req_d    = 1'b1;
                    we_d     = dm_write_i;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_wdata_i;
                    port_d   = PortData;
                    killed_d = 1'b0;
                    err_d    = 1'b0;
                end else if (if_req_i && !if_flush_i) begin
                    state_d  = StFetch;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = if_addr_i;
                    port_d   = PortFetch;
                    killed_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            StData, StFetch: begin
                if ((state_q == StFetch) && if_flush_i) begin
                    killed_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = StResp;
                    req_d   = 1'b0;
                    resp_d  = mem_rdata_i;
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = StResp;
                    req_d   = 1'b0;
                    resp_d  = '0;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (dm_valid_o && !we_q) begin
                    dm_rdata_d = resp_q;
                end
                if (if_valid_o) begin
                    if_rdata_d = resp_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            port_q     <= PortFetch;
            killed_q   <= 1'b0;
            err_q      <= 1'b0;
            resp_q     <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            killed_q   <= killed_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a memory responder and a queue model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, if_flush, dm_read, dm_write, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, stall_if, stall_mem, bus_err, mem_req, mem_we;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        is_data;
        logic        is_store;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    int          plan_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] last_load = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .dm_read_i   (dm_read),
        .dm_write_i  (dm_write),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_valid_o  (dm_valid),
        .stall_if_o  (stall_if),
        .stall_mem_o (stall_mem),
        .bus_err_o   (bus_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int eff(input int a);
        return (a == 0) ? int'(TO) - 1 : a;
    endfunction

    function automatic int rand_ack();
        return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    // ack_at: cycle (counted from mem_req rising, 0-based) on which the memory acks; 0 = never.
    task automatic plan_access(input logic is_data, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ack_at, input logic expect_rsp);
        req_t r;
        rsp_t s;
        plan_q.push_back(ack_at);
        r.addr = addr; r.we = we; r.wdata = wdata;
        req_q.push_back(r);
        s.is_data = is_data; s.is_store = we; s.err = (ack_at == 0); s.rdata = 32'h0;
        if (ack_at != 0) begin
            if (we) ref_mem[addr] = wdata;
            else s.rdata = ref_read(addr);
        end
        if (expect_rsp) rsp_q.push_back(s);
    endtask

    // Memory responder: acks on the planned cycle; a timed-out access gets two stray late acks.
    initial begin
        int active, age, cur, late;
        active = 0; age = 0; cur = 0; late = 0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!rst_n) begin
                active = 0; late = 0;
            end else if (mem_req) begin
                if (active == 0) begin
                    active = 1; age = 0;
                    cur = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
                end else begin
                    age++;
                end
                if (cur != 0 && age == cur) begin
                    mem_ack = 1'b1;
                    if (mem_we) bus_mem[mem_addr] = mem_wdata;
                    else mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr]
                                                               : init_word(mem_addr);
                end
            end else begin
                if (active != 0 && cur == 0) late = 2;
                active = 0;
                if (late > 0) begin
                    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; late--;
                end
            end
        end
    end

    // Monitor: compares issued requests and completions against the scoreboard queues.
    initial begin
        logic        req_prev;
        logic [31:0] held_addr;
        req_t        r;
        rsp_t        s;
        req_prev = 1'b0; held_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
            end else begin
                check_bit("stall_if", stall_if, if_req & ~if_valid);
                check_bit("stall_mem", stall_mem, (dm_read | dm_write) & ~dm_valid);
                if (mem_req && !req_prev) begin
                    if (req_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_req: mem_addr=%h with none expected", mem_addr);
                    end else begin
                        r = req_q.pop_front();
                        check("mem_addr", mem_addr, r.addr);
                        check_bit("mem_we", mem_we, r.we);
                        if (r.we) check("mem_wdata", mem_wdata, r.wdata);
                        held_addr = r.addr;
                    end
                end else if (mem_req) begin
                    check("mem_addr_stable", mem_addr, held_addr);
                end
                if (dm_valid || if_valid) begin
                    if (rsp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_valid: dm_valid=%b if_valid=%b, none expected",
                                 dm_valid, if_valid);
                    end else begin
                        s = rsp_q.pop_front();
                        check_bit("valid_dm", dm_valid, s.is_data);
                        check_bit("valid_if", if_valid, !s.is_data);
                        check_bit("bus_err", bus_err, s.err);
                        if (s.is_data && s.is_store) begin
                            check("store_keeps_dm_rdata", dm_rdata, last_load);
                        end else if (s.is_data) begin
                            check("dm_rdata", dm_rdata, s.rdata);
                            last_load = s.rdata;
                        end else begin
                            check("if_rdata", if_rdata, s.rdata);
                        end
                    end
                end else begin
                    check_bit("bus_err_idle", bus_err, 1'b0);
                end
                req_prev = mem_req;
            end
        end
    end

    // fmode: 0 none, 1 flush during FETCH, 2 flush during RESP and the following IDLE cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] daddr,
                         input logic [31:0] wdata, input int dack, input logic fe,
                         input logic [31:0] faddr, input int fack, input int fmode,
                         input logic [31:0] naddr, input int nack);
        logic dm_busy, if_busy, dm_drop, if_drop;
        int   fs, dm_lat, if_lat, exp_dm, exp_if;
        @(posedge clk); #1;
        if (rd | wr) plan_access(1'b1, wr, daddr, wdata, dack, 1'b1);
        if (fe) plan_access(1'b0, 1'b0, faddr, 32'h0, fack, fmode == 0);
        if (fe && fmode != 0) plan_access(1'b0, 1'b0, naddr, 32'h0, nack, 1'b1);
        dm_read = rd; dm_write = wr; dm_addr = daddr; dm_wdata = wdata;
        if_req = fe; if_addr = faddr;
        dm_busy = rd | wr; if_busy = fe; dm_drop = 1'b0; if_drop = 1'b0;
        fs = 0; dm_lat = 0; if_lat = 0;
        for (int it = 1; it <= 60 && (dm_busy || if_busy); it++) begin
            @(posedge clk); #1;
            if (dm_drop) begin dm_read = 1'b0; dm_write = 1'b0; dm_busy = 1'b0; dm_drop = 1'b0; end
            if (if_drop) begin if_req = 1'b0; if_busy = 1'b0; if_drop = 1'b0; end
            if (fmode == 1) begin
                if (fs == 0 && mem_req) begin if_flush = 1'b1; if_addr = naddr; fs = 1; end
                else if (fs == 1) begin if_flush = 1'b0; fs = 2; end
            end else if (fmode == 2) begin
                if (fs == 0 && mem_req) fs = 1;
                else if (fs == 1 && !mem_req) begin if_flush = 1'b1; if_addr = naddr; fs = 2; end
                else if (fs == 2) fs = 3;
                else if (fs == 3) begin
                    check_bit("flush_blocks_grant", mem_req, 1'b0);
                    if_flush = 1'b0; fs = 4;
                end
            end
            if (dm_busy && dm_valid) begin dm_drop = 1'b1; dm_lat = it; end
            if (if_busy && if_valid && (fmode == 0 || (fmode == 1 && fs >= 2) || fs >= 4)) begin
                if_drop = 1'b1; if_lat = it;
            end
        end
        if (dm_busy || if_busy) begin
            n_checks++; n_fail++;
            $display("FAIL txn_done: dm_busy=%b if_busy=%b after cycle budget", dm_busy, if_busy);
        end
        if (fmode == 0) begin
            exp_dm = 2 + eff(dack);
            exp_if = ((rd | wr) ? exp_dm + 1 : 0) + 2 + eff(fack);
            if (rd | wr) check("dm_latency", dm_lat, exp_dm);
            if (fe) check("if_latency", if_lat, exp_if);
        end
        dm_read = 1'b0; dm_write = 1'b0; if_req = 1'b0; if_flush = 1'b0;
    endtask

    initial begin
        logic [31:0] da, fa, na, wd;
        int          k;
        logic        got;
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] da, fa, na, wd;
        int          k;
        logic        got;
        if_req = 0; if_flush = 0; if_addr = 0;
        dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_mem_req", mem_req, 1'b0);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check_bit("rst_if_valid", if_valid, 1'b0);
        check_bit("rst_dm_valid", dm_valid, 1'b0);
        check_bit("rst_bus_err", bus_err, 1'b0);
        if_req = 1'b1; dm_write = 1'b1; #1;
        check_bit("rst_stall_if_comb", stall_if, 1'b1);
        check_bit("rst_stall_mem_comb", stall_mem, 1'b1);
        if_req = 1'b0; dm_write = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        ref_mem[32'h40] = 32'h00500093; bus_mem[32'h40] = 32'h00500093;
        issue(0, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0, 0);
        issue(1, 0, 32'h100, 0, 2, 1, 32'h44, 1, 0, 0, 0);
        issue(0, 1, 32'h200, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 1, 32'h48, 2, 1, 32'h80, 1);
        issue(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 1, 32'h4C, 1, 2, 32'h84, 2);
        issue(1, 0, 32'h200, 0, 3, 0, 0, 0, 0, 0, 0);
        issue(1, 1, 32'h108, 32'h12345678, 1, 1, 32'h50, 0, 0, 0, 0);
        issue(1, 0, 32'h108, 0, 2, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 7);
            da = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            fa = 32'($urandom_range(0, 63)) * 4;
            na = 32'($urandom_range(0, 63)) * 4;
            wd = $urandom;
            case (k)
                0: issue(0, 0, 0, 0, 0, 1, fa, rand_ack(), 0, 0, 0);
                1: issue(1, 0, da, 0, rand_ack(), 0, 0, 0, 0, 0, 0);
                2: issue(0, 1, da, wd, rand_ack(), 0, 0, 0, 0, 0, 0);
                3: issue(1, 0, da, 0, rand_ack(), 1, fa, rand_ack(), 0, 0, 0);
                4: issue(0, 1, da, wd, rand_ack(), 1, fa, rand_ack(), 0, 0, 0);
                5: issue(0, 0, 0, 0, 0, 1, fa, rand_ack(), 1, na, rand_ack());
                6: issue(0, 0, 0, 0, 0, 1, fa, rand_ack(), 2, na, rand_ack());
                default: issue(1, 1, da, wd, rand_ack(), 0, 0, 0, 0, 0, 0);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Reset in the middle of a data access, with a fetch left pending across it.
        @(posedge clk); #1;
        plan_access(1'b1, 1'b0, 32'h104, 32'h0, 0, 1'b0);
        dm_read = 1'b1; dm_addr = 32'h104; if_req = 1'b1; if_addr = 32'h50;
        for (int i = 0; i < 10 && !mem_req; i++) begin @(posedge clk); #1; end
        check_bit("reset_test_granted", mem_req, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0; dm_read = 1'b0; #1;
        check_bit("mid_rst_mem_req", mem_req, 1'b0);
        check_bit("mid_rst_dm_valid", dm_valid, 1'b0);
        check_bit("mid_rst_if_valid", if_valid, 1'b0);
        check_bit("mid_rst_bus_err", bus_err, 1'b0);
        check("mid_rst_dm_rdata", dm_rdata, 32'h0);
        check("mid_rst_if_rdata", if_rdata, 32'h0);
        last_load = 32'h0;
        plan_access(1'b0, 1'b0, 32'h50, 32'h0, 2, 1'b1);
        @(posedge clk); #2 rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            got = if_valid;
        end
        check_bit("post_reset_fetch_done", got, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (8) @(posedge clk);

        check("req_queue_drained", req_q.size(), 32'h0);
        check("rsp_queue_drained", rsp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
